// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD display converter:
// default geometry and the control state encoding.
package bin2bcd_seq_pkg;

    localparam int DEF_WIDTH  = 10;
    localparam int DEF_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle of the converter: start + binary value in,
// busy/done status and packed BCD digits out.
interface bin2bcd_seq_if
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [DIGITS*4-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries into the next decade.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per clock, result
// held on bcd until the next conversion completes.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
)(
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iSTART,
    input  logic [WIDTH-1:0]     iBIN,
    output logic                 oBUSY,
    output logic                 oDONE,
    output logic [DIGITS*4-1:0]  oBCD
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = DIGITS * 4;

    // The digit field must hold the largest input value.
    generate
        if ((longint'(10) ** DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_range_check
            $error("bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    assign bus.start = iSTART;
    assign bus.bin   = iBIN;
    assign oBUSY     = bus.busy;
    assign oDONE     = bus.done;
    assign oBCD      = bus.bcd;

    state_t                   state_reg;
    logic [BCD_W-1:0]         scratch_reg;
    logic [BCD_W-1:0]         bcd_reg;
    logic [WIDTH-1:0]         bin_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic [BCD_W-1:0]         adj;
    logic [BCD_W+WIDTH-1:0]   shifted;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (scratch_reg[gi*4 +: 4]),
                .dout (adj[gi*4 +: 4])
            );
        end
    endgenerate

    assign shifted = {adj, bin_reg} << 1;

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.bcd  = bcd_reg;

    // Busy drops with the last shift; the following SHIFT cycle with a zero
    // counter only transfers the scratch into the output register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg   <= ST_IDLE;
            scratch_reg <= '0;
            bcd_reg     <= '0;
            bin_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        bin_reg     <= bus.bin;
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_W'(WIDTH);
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SHIFT;
                    end else begin
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg != '0) begin
                        {scratch_reg, bin_reg} <= shifted;
                        cnt_reg  <= cnt_reg - 1'b1;
                        busy_reg <= (cnt_reg > CNT_W'(1));
                    end else begin
                        bcd_reg   <= scratch_reg;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, back-to-back starts, ignored
// mid-conversion starts, reset abort and a full sweep against a decimal model.
module tb_bin2bcd_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt;
    int   busy_cnt;
    int   lat;

    bin2bcd_seq_if #(.WIDTH(10), .DIGITS(4)) bus ();

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iSTART (bus.start),
        .iBIN   (bus.bin),
        .oBUSY  (bus.busy),
        .oDONE  (bus.done),
        .oBCD   (bus.bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic nibbles_ok(input logic [15:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (bus.done !== 1'b1 && l < 40) begin
            step();
            l++;
        end
    endtask

    task automatic start_conv(input logic [9:0] v);
        bus.start = 1'b1;
        bus.bin   = v;
        step();
        bus.start = 1'b0;
        bus.bin   = 10'($urandom);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        step();
        step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd",  32'(bus.bcd),  32'h0);
        rst = 1'b0;
        step();

        // Zero input
        start_conv(10'd0);
        wait_done(lat);
        check("zero_latency", 32'(lat), 32'd11);
        check("zero_bcd", 32'(bus.bcd), 32'h0000);
        $display("conv 0: latency %0d bcd %04h", lat, bus.bcd);
        step();

        // Full-scale input and busy duration
        busy_cnt = 0;
        start_conv(10'd1023);
        wait_done(lat);
        check("max_latency", 32'(lat), 32'd11);
        check("max_bcd", 32'(bus.bcd), 32'h1023);
        check("max_busy_cycles", 32'(busy_cnt), 32'd10);
        $display("conv 1023: latency %0d bcd %04h busy %0d", lat, bus.bcd, busy_cnt);
        step();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("bcd_held", 32'(bus.bcd), 32'h1023);

        // Back-to-back: second start issued in the DONE cycle
        start_conv(10'd599);
        wait_done(lat);
        check("b2b_first_bcd", 32'(bus.bcd), 32'h0599);
        check("b2b_first_latency", 32'(lat), 32'd11);
        $display("conv 599: latency %0d bcd %04h", lat, bus.bcd);
        start_conv(10'd5);
        check("b2b_no_gap_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("b2b_second_latency", 32'(lat), 32'd11);
        check("b2b_second_bcd", 32'(bus.bcd), 32'h0005);
        $display("conv 5 (b2b): latency %0d bcd %04h", lat, bus.bcd);
        step();

        // Start during SHIFT is ignored
        done_cnt = 0;
        start_conv(10'd1000);
        repeat (3) step();
        bus.start = 1'b1;
        bus.bin   = 10'd7;
        step();
        bus.start = 1'b0;
        wait_done(lat);
        check("ignore_latency", 32'(lat + 4), 32'd11);
        check("ignore_bcd", 32'(bus.bcd), 32'h1000);
        repeat (5) step();
        check("ignore_done_count", 32'(done_cnt), 32'd1);
        $display("conv 1000 with stray start: bcd %04h dones %0d", bus.bcd, done_cnt);

        // Reset mid-conversion after a prior 42 result; reset beats start
        start_conv(10'd42);
        wait_done(lat);
        check("prior_bcd", 32'(bus.bcd), 32'h0042);
        step();
        start_conv(10'd999);
        repeat (4) step();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.bin   = 10'd3;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort_bcd",  32'(bus.bcd),  32'h0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        done_cnt = 0;
        busy_cnt = 0;
        repeat (15) step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(busy_cnt), 32'd0);
        $display("reset during 999: bcd %04h dones %0d", bus.bcd, done_cnt);

        // Exhaustive sweep
        for (int v = 0; v < 1024; v++) begin
            start_conv(10'(v));
            wait_done(lat);
            check("sweep_bcd", 32'(bus.bcd), 32'(ref_bcd(v)));
            check("sweep_digit_range", 32'(nibbles_ok(bus.bcd)), 32'd1);
            if (lat != 11) check("sweep_latency", 32'(lat), 32'd11);
            step();
        end
        $display("sweep 0..1023 complete");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
